encoder4_2_rr: RTL and testbench



---
 rtl/encoder4_2_rr.sv | 73 +++++++
 tb/tb_encoder4_2_rr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/encoder4_2_rr.sv
// Registered 4-to-2 priority encoder with valid/ready handshake on both sides.
// Define ENCODER4_2_RR_EN for round-robin search order; undefined gives fixed priority (bit 0 first).
module encoder4_2_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic       out_multi,
    output logic       out_none
);

    logic       accept;
    logic       sel_found;
    logic [1:0] sel_code;
    logic [1:0] idx;

`ifdef ENCODER4_2_RR_EN
    logic [1:0] ptr;
`else
    localparam logic [1:0] ptr = 2'b00;
`endif

    // A full result register can still take a new input when the consumer drains it this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // NOTE: every variable written here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        sel_code  = 2'b00;
        sel_found = 1'b0;
        idx       = 2'b00;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!sel_found && in_req[idx]) begin
                sel_code  = idx;
                sel_found = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= 2'b00;
            out_multi <= 1'b0;
            out_none  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_code  <= sel_code;
            out_multi <= ($countones(in_req) >= 2);
            out_none  <= ~sel_found;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ENCODER4_2_RR_EN
    // A zero request leaves the search start where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'b00;
        end else if (accept && sel_found) begin
            ptr <= sel_code + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_encoder4_2_rr.sv
// Self-checking bench for encoder4_2_rr: directed test-plan steps followed by random traffic,
// all compared against an index-search model of the round-robin / fixed-priority rules.
module tb_encoder4_2_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_req;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_multi;
    logic       out_none;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ptr;
    bit m_valid;
    int m_code;
    bit m_multi;
    bit m_none;

    always #5 clk = ~clk;

    encoder4_2_rr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_multi (out_multi),
        .out_none  (out_none)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_code  = 0;
        m_multi = 0;
        m_none  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, m_valid});
        check({tag, ".out_code"},  {2'b0, out_code},  4'(m_code));
        check({tag, ".out_multi"}, {3'b0, out_multi}, {3'b0, m_multi});
        check({tag, ".out_none"},  {3'b0, out_none},  {3'b0, m_none});
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and the result register after it.
    task automatic step(input string tag, input bit v, input logic [3:0] req, input bit rdy);
        bit acc, cons;
        int found, bits;
        in_valid  = v;
        in_req    = req;
        out_ready = rdy;
        #1;
        check({tag, ".in_ready"}, {3'b0, in_ready}, {3'b0, (!m_valid || rdy)});
        @(posedge clk);
        acc  = v && (!m_valid || rdy);
        cons = m_valid && rdy;
        if (acc) begin
            found = -1;
            bits  = 0;
            for (int i = 0; i < 4; i++) begin
                if (req[(m_ptr + i) % 4] && found < 0) found = (m_ptr + i) % 4;
                if (req[i]) bits++;
            end
            m_valid = 1;
            m_code  = (found < 0) ? 0 : found;
            m_none  = (found < 0);
            m_multi = (bits >= 2);
`ifdef ENCODER4_2_RR_EN
            if (found >= 0) m_ptr = (found + 1) % 4;
`endif
        end else if (cons) begin
            m_valid = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_req    = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        #2;
        check("reset.in_ready", {3'b0, in_ready}, 4'h1);
        check_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset.in_ready", {3'b0, in_ready}, 4'h1);

        // Five all-ones requests with the consumer always ready.
        for (int i = 0; i < 5; i++) step("all_ones", 1, 4'b1111, 1);

        // Single then double request.
        step("single", 1, 4'b0100, 1);
        step("double", 1, 4'b0101, 1);

        // Zero request is reported and leaves the pointer alone.
        step("zero", 1, 4'b0000, 1);
        step("after_zero", 1, 4'b0010, 1);

        // Back-pressure: held result ignores in_req changes until drained.
        step("bp_load", 1, 4'b1000, 0);
        for (int i = 0; i < 3; i++) step("bp_hold", 1, 4'b0001, 0);
        step("bp_swap", 1, 4'b0001, 1);
        step("bp_drain", 0, 4'b0000, 1);

        // Reset with a pending result.
        step("rst_load", 1, 4'b0010, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_reset.out_valid", {3'b0, out_valid}, 4'h0);
        check("mid_reset.in_ready", {3'b0, in_ready}, 4'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset", 1, 4'b1111, 1);

        // Idle cycles with the consumer ready, then a probe of the pointer.
        for (int i = 0; i < 3; i++) step("idle", 0, 4'b1010, 1);
        step("idle_probe", 1, 4'b1111, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
        step("final_drain", 0, 4'b0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
